// File: rtl/div_unit.sv
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle RV64M divide/remainder unit (restoring, 1 bit/cycle)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            is_signed,
    input  logic            is_rem,
    input  logic            is_word,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;
    localparam logic [5:0] c_last_d  = 6'd63;
    localparam logic [5:0] c_last_w  = 6'd31;

    logic [1:0]      r_state, w_state_nxt;
    logic [5:0]      r_cnt;
    logic [XLEN-1:0] r_quot, r_rem, r_div, r_result;
    logic            r_neg_q, r_neg_r, r_is_rem, r_is_word;

    logic            w_a_neg, w_b_neg, w_b_zero, w_ovf, w_special, w_accept, w_last;
    logic [31:0]     w_a_abs32, w_b_abs32;
    logic [XLEN-1:0] w_a_abs, w_b_abs, w_a_sext, w_special_res;
    logic [XLEN:0]   w_shift, w_trial;
    logic            w_fit;
    logic [XLEN-1:0] w_quot_nxt, w_rem_nxt, w_q_raw, w_r_raw, w_q_fix, w_r_fix, w_sel, w_final;

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign result    = r_result;
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_last    = (r_cnt == (r_is_word ? c_last_w : c_last_d));

    always_comb begin
        w_a_neg   = is_signed & (is_word ? dividend[31] : dividend[XLEN-1]);
        w_b_neg   = is_signed & (is_word ? divisor[31]  : divisor[XLEN-1]);
        w_a_abs   = w_a_neg ? ({XLEN{1'b0}} - dividend) : dividend;
        w_b_abs   = w_b_neg ? ({XLEN{1'b0}} - divisor)  : divisor;
        w_a_abs32 = w_a_neg ? (32'd0 - dividend[31:0]) : dividend[31:0];
        w_b_abs32 = w_b_neg ? (32'd0 - divisor[31:0])  : divisor[31:0];
        w_a_sext  = is_word ? {{(XLEN-32){dividend[31]}}, dividend[31:0]} : dividend;
        w_b_zero  = is_word ? (divisor[31:0] == 32'd0) : (divisor == {XLEN{1'b0}});
        w_ovf     = is_signed & (is_word
                    ? ((dividend[31:0] == 32'h8000_0000) && (divisor[31:0] == 32'hFFFF_FFFF))
                    : ((dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == {XLEN{1'b1}})));
        w_special = w_b_zero | w_ovf;
        // Divide-by-zero wins over overflow: divisor -1 can never be zero anyway
        if (w_b_zero) begin
            w_special_res = is_rem ? w_a_sext : {XLEN{1'b1}};
        end else begin
            w_special_res = is_rem ? {XLEN{1'b0}} : w_a_sext;
        end
    end

    // W operands are left-aligned so the next dividend bit is always the MSB
    always_comb begin
        w_shift    = {r_rem, r_quot[XLEN-1]};
        w_trial    = w_shift - {1'b0, r_div};
        w_fit      = ~w_trial[XLEN];
        w_rem_nxt  = w_fit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
        w_quot_nxt = {r_quot[XLEN-2:0], w_fit};
        w_q_raw    = r_is_word ? {{(XLEN-32){1'b0}}, w_quot_nxt[31:0]} : w_quot_nxt;
        w_r_raw    = r_is_word ? {{(XLEN-32){1'b0}}, w_rem_nxt[31:0]}  : w_rem_nxt;
        w_q_fix    = r_neg_q ? ({XLEN{1'b0}} - w_q_raw) : w_q_raw;
        w_r_fix    = r_neg_r ? ({XLEN{1'b0}} - w_r_raw) : w_r_raw;
        w_sel      = r_is_rem ? w_r_fix : w_q_fix;
        w_final    = r_is_word ? {{(XLEN-32){w_sel[31]}}, w_sel[31:0]} : w_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: if (in_valid)  w_state_nxt = w_special ? c_st_done : c_st_busy;
                c_st_busy: if (w_last)    w_state_nxt = c_st_done;
                c_st_done: if (out_ready) w_state_nxt = c_st_idle;
                default:                  w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_result  <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
            r_is_word <= 1'b0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_is_rem  <= is_rem;
            r_is_word <= is_word;
            r_quot    <= is_word ? {w_a_abs32, 32'd0} : w_a_abs;
            r_div     <= is_word ? {{(XLEN-32){1'b0}}, w_b_abs32} : w_b_abs;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (r_state == c_st_busy) begin
            r_quot <= w_quot_nxt;
            r_rem  <= w_rem_nxt;
            r_cnt  <= r_cnt + 6'd1;
            if (w_last) begin
                r_result <= w_final;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit against an arithmetic model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, is_signed, is_rem, is_word, flush;
    logic        out_valid, out_ready;
    logic [63:0] dividend, divisor, result;

    int errors = 0;
    int checks = 0;

    div_unit #(.XLEN(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .is_rem    (is_rem),
        .is_word   (is_word),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    // RV64M semantics straight from the ISA rules using native SV division
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input bit s, input bit r, input bit w);
        logic [31:0]        a32, b32, q32;
        logic signed [31:0] a32s, b32s;
        logic signed [63:0] as, bs;
        logic [63:0]        q64;
        if (w) begin
            a32 = a[31:0]; b32 = b[31:0]; a32s = a32; b32s = b32;
            if (b32 == 32'd0)                                            q32 = r ? a32 : 32'hFFFF_FFFF;
            else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) q32 = r ? 32'd0 : a32;
            else if (s)                                                  q32 = r ? a32s % b32s : a32s / b32s;
            else                                                         q32 = r ? a32 % b32 : a32 / b32;
            return {{32{q32[31]}}, q32};
        end
        as = a; bs = b;
        if (b == 64'd0)                                      q64 = r ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) q64 = r ? 64'd0 : a;
        else if (s)                                          q64 = r ? as % bs : as / bs;
        else                                                 q64 = r ? a % b : a / b;
        return q64;
    endfunction

    function automatic int exp_lat(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w);
        bit zero, ovf;
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = s && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
        return (zero || ovf) ? 1 : (w ? 33 : 65);
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_8000_0000;
            4:       return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op from IDLE; latency counts edges from acceptance to out_valid
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit s, input bit r,
                          input bit w, input bit drain, output logic [63:0] res,
                          output int lat, output bit to);
        dividend = a; divisor = b; is_signed = s; is_rem = r; is_word = w; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
        to  = !out_valid;
        res = result;
        if (drain) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
        step(); step();
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 64'd0)   begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    endtask

    task automatic test_directed();
        logic [63:0] ta [10] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_FFFF_FFFF,
                                 64'h25, 64'd5, 64'd5, 64'h0000_0000_8000_0001, 64'h8000_0000_0000_0000,
                                 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
        logic [63:0] tb [10] = '{64'd2, 64'd2, 64'd1, 64'h10, 64'd0, 64'd0, 64'd0,
                                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [2:0]  tf [10] = '{3'b100, 3'b110, 3'b001, 3'b011, 3'b000, 3'b110, 3'b111, 3'b100, 3'b110, 3'b101};
        logic [63:0] te [10] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_8000_0001,
                                 64'h8000_0000_0000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000};
        int          tl [10] = '{65, 65, 33, 33, 1, 1, 1, 1, 1, 1};
        logic [63:0] res;
        int          lat;
        bit          to;
        for (int i = 0; i < 10; i++) begin
            run_op(ta[i], tb[i], tf[i][2], tf[i][1], tf[i][0], 1'b1, res, lat, to);
            checks++; if (to) begin errors++; $display("FAIL dir%0d_timeout: out_valid never seen", i); end
            checks++; if (res !== te[i]) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, res, te[i]); end
            checks++; if (lat !== tl[i]) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, tl[i]); end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, res, exp;
        bit          s, r, w, to;
        int          lat, el;
        for (int i = 0; i < 60; i++) begin
            a = pick(); b = pick();
            s = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
            exp = model(a, b, s, r, w);
            el  = exp_lat(a, b, s, w);
            run_op(a, b, s, r, w, 1'b1, res, lat, to);
            checks++; if (res !== exp) begin errors++; $display("FAIL rnd%0d_result: a=%h b=%h s%0d r%0d w%0d got %h expected %h", i, a, b, s, r, w, res, exp); end
            checks++; if (lat !== el)  begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, el); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] res, exp;
        int          lat;
        bit          to;
        exp = model(64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0, 1'b0);
        run_op(64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0, 1'b0, 1'b0, res, lat, to);
        checks++; if (res !== exp) begin errors++; $display("FAIL bp_first: got %h expected %h", res, exp); end
        // A special-case op offered while stalled would complete instantly if wrongly taken
        dividend = 64'd5; divisor = 64'd0; is_signed = 1'b0; is_rem = 1'b1; is_word = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b rdy=%b res=%h expected v=1 rdy=0 res=%h", k, out_valid, in_ready, result, exp);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_accept: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_abort(input bit use_reset);
        logic [63:0] res;
        int          lat, seen;
        bit          to;
        // Abort while idle with a pending instant op: nothing may be accepted
        dividend = 64'd5; divisor = 64'd0; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0; in_valid = 1'b1;
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort%0d_idle: got v=%b rdy=%b expected v=0 rdy=1", use_reset, out_valid, in_ready); end
        dividend = 64'hFFFF_FFFF_FFFF_FFFF; divisor = 64'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) step();
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort%0d_busy: got v=%b rdy=%b expected v=0 rdy=1", use_reset, out_valid, in_ready); end
        if (use_reset) begin
            checks++; if (result !== 64'd0) begin errors++; $display("FAIL abort_reset_result: got %h expected 0", result); end
        end
        seen = 0;
        for (int k = 0; k < 70; k++) begin
            step();
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort%0d_quiet: got %0d valid cycles expected 0", use_reset, seen); end
        run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 1'b1, res, lat, to);
        checks++; if (res !== 64'd14) begin errors++; $display("FAIL abort%0d_next_result: got %h expected 14", use_reset, res); end
        checks++; if (lat !== 65)     begin errors++; $display("FAIL abort%0d_next_latency: got %0d expected 65", use_reset, lat); end
    endtask

    task automatic test_flush_done();
        logic [63:0] res;
        int          lat;
        bit          to;
        run_op(64'd9, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, res, lat, to);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_done: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ea, eb;
        ea = model(64'h1234_5678_8000_0001, 64'd0, 1'b1, 1'b1, 1'b1);
        eb = model(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        dividend = 64'h1234_5678_8000_0001; divisor = 64'd0; is_signed = 1'b1; is_rem = 1'b1; is_word = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || result !== ea) begin errors++; $display("FAIL b2b_first: got v=%b res=%h expected v=1 res=%h", out_valid, result, ea); end
        dividend = 64'h8000_0000_0000_0000; divisor = 64'hFFFF_FFFF_FFFF_FFFF; is_rem = 1'b0; is_word = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== eb) begin errors++; $display("FAIL b2b_second: got v=%b res=%h expected v=1 res=%h", out_valid, result, eb); end
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_directed();
        test_backpressure();
        test_abort(1'b0);
        test_abort(1'b1);
        test_flush_done();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
